// File: rtl/event_ring_buffer.sv
// event_ring_buffer
// Multi-slot event buffer between the event builder and the readout register
// interface. The writer fills the current write slot in narrow words and
// commits it with evt_done_i. The reader reads the oldest committed slot in
// wide words and releases it with clear_evt_i. A committed slot is never
// overwritten before it has been released.
module event_ring_buffer #(
    parameter int unsigned NBUF      = 4,
    parameter int unsigned NBUF_BITS = 2,
    parameter int unsigned WR_DW     = 16,
    parameter int unsigned RD_AW     = 6,
    parameter int unsigned WR_AW     = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [WR_AW-1:0]       evt_wr_addr_i,
    input  logic [WR_DW-1:0]       evt_wr_dat_i,
    input  logic                   evt_wr_i,
    input  logic                   evt_done_i,
    input  logic [RD_AW-1:0]       evt_rd_addr_i,
    output logic [2*WR_DW-1:0]     evt_rd_dat_o,
    input  logic                   clear_evt_i,
    output logic [NBUF_BITS-1:0]   read_buffer_o,
    output logic [NBUF_BITS-1:0]   write_buffer_o,
    output logic [NBUF_BITS:0]     evt_count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    input  logic                   err_clr_i
);

    localparam int unsigned RD_DW     = 2 * WR_DW;
    localparam int unsigned MEM_AW    = NBUF_BITS + RD_AW;
    localparam int unsigned MEM_DEPTH = NBUF * (2 ** RD_AW);

    localparam logic [NBUF_BITS:0]   CNT_FULL = (NBUF_BITS+1)'(NBUF);
    localparam logic [NBUF_BITS:0]   CNT_ONE  = (NBUF_BITS+1)'(1);
    localparam logic [NBUF_BITS-1:0] PTR_ONE  = NBUF_BITS'(1);

    // Slot storage; deliberately not reset.
    logic [RD_DW-1:0] mem_q [MEM_DEPTH];

    logic [NBUF_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [NBUF_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [NBUF_BITS:0]   count_q,  count_d;
    logic                 full_q,   full_d;
    logic                 empty_q,  empty_d;
    logic                 ovf_q,    ovf_d;
    logic                 unf_q,    unf_d;
    logic [NBUF_BITS-1:0] rd_buf_q;
    logic [RD_DW-1:0]     rd_dat_q;

    logic                 wr_accept;
    logic                 commit_ok;
    logic                 release_ok;
    logic [MEM_AW-1:0]    wr_mem_addr;
    logic [MEM_AW-1:0]    rd_mem_addr;

    // Acceptance is decided from the registered flags, so a commit and a
    // release in the same cycle resolve against the state before that cycle.
    assign wr_accept  = evt_wr_i    & ~full_q;
    assign commit_ok  = evt_done_i  & ~full_q;
    assign release_ok = clear_evt_i & ~empty_q;

    assign wr_mem_addr = {wr_ptr_q, evt_wr_addr_i[WR_AW-1:1]};
    assign rd_mem_addr = {rd_ptr_q, evt_rd_addr_i};

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (commit_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (release_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({commit_ok, release_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);

        if (full_q && (evt_wr_i || evt_done_i)) begin
            ovf_d = 1'b1;
        end
        if (empty_q && clear_evt_i) begin
            unf_d = 1'b1;
        end

        // A clear wins over a flag being raised in the same cycle.
        if (err_clr_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Narrow-word write into the low or high half of the addressed wide word.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            if (evt_wr_addr_i[0]) begin
                mem_q[wr_mem_addr][RD_DW-1:WR_DW] <= evt_wr_dat_i;
            end else begin
                mem_q[wr_mem_addr][WR_DW-1:0] <= evt_wr_dat_i;
            end
        end
    end

    // Registered read port; read_buffer_o trails rd_ptr to line up with data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_dat_q <= '0;
            rd_buf_q <= '0;
        end else begin
            rd_dat_q <= mem_q[rd_mem_addr];
            rd_buf_q <= rd_ptr_q;
        end
    end

    assign evt_rd_dat_o   = rd_dat_q;
    assign read_buffer_o  = rd_buf_q;
    assign write_buffer_o = wr_ptr_q;
    assign evt_count_o    = count_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_event_ring_buffer.sv
// tb_event_ring_buffer
// Directed bench for event_ring_buffer with NBUF=4, WR_DW=16, RD_AW=6.
module tb_event_ring_buffer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [6:0]  evt_wr_addr_i = '0;
    logic [15:0] evt_wr_dat_i = '0;
    logic        evt_wr_i = 1'b0;
    logic        evt_done_i = 1'b0;
    logic [5:0]  evt_rd_addr_i = '0;
    logic [31:0] evt_rd_dat_o;
    logic        clear_evt_i = 1'b0;
    logic [1:0]  read_buffer_o;
    logic [1:0]  write_buffer_o;
    logic [2:0]  evt_count_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        err_clr_i = 1'b0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    event_ring_buffer #(
        .NBUF(4),
        .NBUF_BITS(2),
        .WR_DW(16),
        .RD_AW(6),
        .WR_AW(7)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .evt_wr_addr_i(evt_wr_addr_i),
        .evt_wr_dat_i(evt_wr_dat_i),
        .evt_wr_i(evt_wr_i),
        .evt_done_i(evt_done_i),
        .evt_rd_addr_i(evt_rd_addr_i),
        .evt_rd_dat_o(evt_rd_dat_o),
        .clear_evt_i(clear_evt_i),
        .read_buffer_o(read_buffer_o),
        .write_buffer_o(write_buffer_o),
        .evt_count_o(evt_count_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .overflow_o(overflow_o),
        .underflow_o(underflow_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        evt_wr_i    = 1'b0;
        evt_done_i  = 1'b0;
        clear_evt_i = 1'b0;
        err_clr_i   = 1'b0;
        evt_wr_addr_i = '0;
        evt_wr_dat_i  = '0;
        evt_rd_addr_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic write_word(input logic [6:0] a, input logic [15:0] d);
        evt_wr_addr_i = a;
        evt_wr_dat_i  = d;
        evt_wr_i      = 1'b1;
        tick();
        evt_wr_i      = 1'b0;
    endtask

    task automatic pulse_done();
        evt_done_i = 1'b1;
        tick();
        evt_done_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_evt_i = 1'b1;
        tick();
        clear_evt_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n_i = 1'b0;
        tick();
        tick();
        n_total++;
        if (evt_rd_dat_o !== 32'h0) $display("FAIL reset_rd_dat: got %h expected %h", evt_rd_dat_o, 32'h0);
        else n_pass++;
        rst_n_i = 1'b1;
        tick();
        tick();
        n_total++;
        if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty_o);
        else n_pass++;
        n_total++;
        if (full_o !== 1'b0) $display("FAIL reset_full: got %b expected 0", full_o);
        else n_pass++;
        n_total++;
        if (evt_count_o !== 3'd0) $display("FAIL reset_count: got %0d expected 0", evt_count_o);
        else n_pass++;
        n_total++;
        if (read_buffer_o !== 2'd0 || write_buffer_o !== 2'd0)
            $display("FAIL reset_ptrs: got rd=%0d wr=%0d expected rd=0 wr=0", read_buffer_o, write_buffer_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b0 || underflow_o !== 1'b0)
            $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", overflow_o, underflow_o);
        else n_pass++;
    endtask

    task automatic test_single_event();
        do_reset();
        write_word(7'd0, 16'h1234);
        write_word(7'd1, 16'hABCD);
        pulse_done();
        evt_rd_addr_i = 6'd0;
        tick();
        n_total++;
        if (evt_rd_dat_o !== 32'hABCD1234) $display("FAIL single_rd_dat: got %h expected %h", evt_rd_dat_o, 32'hABCD1234);
        else n_pass++;
        n_total++;
        if (evt_count_o !== 3'd1) $display("FAIL single_count: got %0d expected 1", evt_count_o);
        else n_pass++;
        n_total++;
        if (write_buffer_o !== 2'd1) $display("FAIL single_wr_buf: got %0d expected 1", write_buffer_o);
        else n_pass++;
        n_total++;
        if (empty_o !== 1'b0) $display("FAIL single_empty: got %b expected 0", empty_o);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] lo;
        logic [15:0] hi;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lo = 16'h1000 + 16'(i);
            hi = 16'h2000 + 16'(i);
            write_word(7'd0, lo);
            write_word(7'd1, hi);
            pulse_done();
        end
        n_total++;
        if (full_o !== 1'b1 || evt_count_o !== 3'd4)
            $display("FAIL ovf_full: got full=%b count=%0d expected full=1 count=4", full_o, evt_count_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_before: got %b expected 0", overflow_o);
        else n_pass++;
        write_word(7'd0, 16'hDEAD);
        n_total++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_on_write: got %b expected 1", overflow_o);
        else n_pass++;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        pulse_done();
        n_total++;
        if (write_buffer_o !== 2'd0 || evt_count_o !== 3'd4)
            $display("FAIL ovf_commit_drop: got wr=%0d count=%0d expected wr=0 count=4", write_buffer_o, evt_count_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_on_commit: got %b expected 1", overflow_o);
        else n_pass++;
        evt_rd_addr_i = 6'd0;
        tick();
        n_total++;
        if (evt_rd_dat_o !== 32'h20001000) $display("FAIL ovf_ram_kept: got %h expected %h", evt_rd_dat_o, 32'h20001000);
        else n_pass++;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        n_total++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow_o);
        else n_pass++;
        // clear and a new overflow attempt in the same cycle: clear wins
        err_clr_i  = 1'b1;
        evt_done_i = 1'b1;
        tick();
        err_clr_i  = 1'b0;
        evt_done_i = 1'b0;
        n_total++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_clr_priority: got %b expected 0", overflow_o);
        else n_pass++;
    endtask

    task automatic test_underflow_wrap();
        logic [1:0]  exp_ptr;
        logic [31:0] exp_dat;
        do_reset();
        pulse_clear();
        n_total++;
        if (underflow_o !== 1'b1) $display("FAIL unf_set: got %b expected 1", underflow_o);
        else n_pass++;
        tick();
        n_total++;
        if (read_buffer_o !== 2'd0 || evt_count_o !== 3'd0)
            $display("FAIL unf_ptr_hold: got rd=%0d count=%0d expected rd=0 count=0", read_buffer_o, evt_count_o);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            exp_ptr = 2'((i + 1) % 4);
            exp_dat = {16'h4000 + 16'(i), 16'h3000 + 16'(i)};
            write_word(7'd2, 16'h3000 + 16'(i));
            write_word(7'd3, 16'h4000 + 16'(i));
            pulse_done();
            n_total++;
            if (write_buffer_o !== exp_ptr) $display("FAIL wrap_wr_buf[%0d]: got %0d expected %0d", i, write_buffer_o, exp_ptr);
            else n_pass++;
            evt_rd_addr_i = 6'd1;
            tick();
            n_total++;
            if (evt_rd_dat_o !== exp_dat) $display("FAIL wrap_rd_dat[%0d]: got %h expected %h", i, evt_rd_dat_o, exp_dat);
            else n_pass++;
            pulse_clear();
            tick();
            n_total++;
            if (read_buffer_o !== exp_ptr || evt_count_o !== 3'd0)
                $display("FAIL wrap_rd_buf[%0d]: got rd=%0d count=%0d expected rd=%0d count=0", i, read_buffer_o, evt_count_o, exp_ptr);
            else n_pass++;
        end
        n_total++;
        if (underflow_o !== 1'b1) $display("FAIL unf_sticky: got %b expected 1", underflow_o);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 4; i++) pulse_done();
        evt_done_i  = 1'b1;
        clear_evt_i = 1'b1;
        tick();
        evt_done_i  = 1'b0;
        clear_evt_i = 1'b0;
        n_total++;
        if (evt_count_o !== 3'd3 || full_o !== 1'b0)
            $display("FAIL sim_full_count: got count=%0d full=%b expected count=3 full=0", evt_count_o, full_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b1 || write_buffer_o !== 2'd0)
            $display("FAIL sim_full_reject: got ovf=%b wr=%0d expected ovf=1 wr=0", overflow_o, write_buffer_o);
        else n_pass++;
        n_total++;
        if (read_buffer_o !== 2'd0) $display("FAIL sim_rd_buf_lag: got %0d expected 0", read_buffer_o);
        else n_pass++;
        tick();
        n_total++;
        if (read_buffer_o !== 2'd1) $display("FAIL sim_rd_buf_late: got %0d expected 1", read_buffer_o);
        else n_pass++;
        pulse_clear();
        evt_done_i  = 1'b1;
        clear_evt_i = 1'b1;
        tick();
        evt_done_i  = 1'b0;
        clear_evt_i = 1'b0;
        n_total++;
        if (evt_count_o !== 3'd2 || write_buffer_o !== 2'd1)
            $display("FAIL sim_mid: got count=%0d wr=%0d expected count=2 wr=1", evt_count_o, write_buffer_o);
        else n_pass++;
        tick();
        n_total++;
        if (read_buffer_o !== 2'd3) $display("FAIL sim_mid_rd_buf: got %0d expected 3", read_buffer_o);
        else n_pass++;
        pulse_clear();
        pulse_clear();
        evt_done_i  = 1'b1;
        clear_evt_i = 1'b1;
        tick();
        evt_done_i  = 1'b0;
        clear_evt_i = 1'b0;
        n_total++;
        if (evt_count_o !== 3'd1 || write_buffer_o !== 2'd2 || underflow_o !== 1'b1)
            $display("FAIL sim_empty: got count=%0d wr=%0d unf=%b expected count=1 wr=2 unf=1", evt_count_o, write_buffer_o, underflow_o);
        else n_pass++;
        tick();
        n_total++;
        if (read_buffer_o !== 2'd1) $display("FAIL sim_empty_rd_buf: got %0d expected 1", read_buffer_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_done();
        pulse_done();
        pulse_clear();
        tick();
        pulse_done();
        n_total++;
        if (evt_count_o !== 3'd2 || read_buffer_o !== 2'd1)
            $display("FAIL arst_pre: got count=%0d rd=%0d expected count=2 rd=1", evt_count_o, read_buffer_o);
        else n_pass++;
        evt_wr_addr_i = 7'd4;
        evt_wr_dat_i  = 16'h5555;
        evt_wr_i      = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        n_total++;
        if (evt_count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0)
            $display("FAIL arst_state: got count=%0d empty=%b full=%b expected 0 1 0", evt_count_o, empty_o, full_o);
        else n_pass++;
        n_total++;
        if (read_buffer_o !== 2'd0 || write_buffer_o !== 2'd0 || evt_rd_dat_o !== 32'h0)
            $display("FAIL arst_outputs: got rd=%0d wr=%0d dat=%h expected 0 0 0", read_buffer_o, write_buffer_o, evt_rd_dat_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b0 || underflow_o !== 1'b0)
            $display("FAIL arst_flags: got ovf=%b unf=%b expected 0 0", overflow_o, underflow_o);
        else n_pass++;
        idle_inputs();
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_overflow();
        test_underflow_wrap();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
